// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master arbiter and two-state access sequencer for the byte-lane data RAM
module ram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state;
  logic        prio, id, we_q, win, grant, access;
  logic [3:0]  sel_q;
  logic [31:0] addr_q, wdata_q;
  // prio only breaks a tie; a lone requester always wins
  always_comb begin
    win = (m0_req & m1_req) ? prio : m1_req;
    grant = (state == IDLE) & ~rst & (m0_req | m1_req);
    access = state == ACCESS;
  end
  assign m0_gnt    = grant & ~win;
  assign m1_gnt    = grant & win;
  assign ram_we    = access & we_q & ~rst;
  assign ram_sel   = access ? sel_q : '0;
  assign ram_addr  = access ? addr_q : '0;
  assign ram_wdata = access ? wdata_q : '0;
  // latch the winner in IDLE, run one RAM cycle, then register the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      id <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= grant ? ACCESS : IDLE;
      m0_ack <= access & ~id;
      m1_ack <= access & id;
      m0_rdata <= (access & ~id & ~we_q) ? ram_rdata : '0;
      m1_rdata <= (access & id & ~we_q) ? ram_rdata : '0;
      if (grant) begin
        prio <= ~win;
        id <= win;
        we_q <= win ? m1_we : m0_we;
        sel_q <= win ? m1_sel : m0_sel;
        addr_q <= win ? m1_addr : m0_addr;
        wdata_q <= win ? m1_wdata : m0_wdata;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural RAM and reference model
module tb_ram_arbiter;
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic        r_req[2], r_we[2];
  logic [3:0]  r_sel[2];
  logic [31:0] r_addr[2], r_wdata[2];
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack, ram_we;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  bit [31:0] mem[64];
  bit [31:0] ref_mem[64];
  txn_t  plan0[$], plan1[$];
  resp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit checking = 0, cont = 0, rnd = 0, alt_chk = 0, alt_exp = 0;
  bit g_seen[2];
  int last_gcyc = -1;

  bit   busy = 0, prio = 0, pid = 0;
  txn_t pend;
  int   pcyc = 0;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(r_req[0]), .m0_we(r_we[0]), .m0_sel(r_sel[0]), .m0_addr(r_addr[0]), .m0_wdata(r_wdata[0]),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(r_req[1]), .m1_we(r_we[1]), .m1_sel(r_sel[1]), .m1_addr(r_addr[1]), .m1_wdata(r_wdata[1]),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ram_rdata = ram_we ? 32'h0 : mem[ram_addr[7:2]];
  always @(posedge clk)
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.sel = sel; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom), 4'($urandom), {24'h0, 8'($urandom)}, $urandom);
  endfunction

  task automatic load(input int i, input txn_t t);
    r_req[i] = 1'b1; r_we[i] = t.we; r_sel[i] = t.sel; r_addr[i] = t.addr; r_wdata[i] = t.wdata;
  endtask

  // driver: present planned or random transactions, drop req after grant
  initial begin
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 0; r_we[i] = 0; r_sel[i] = 0; r_addr[i] = 0; r_wdata[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (r_req[i] && g_seen[i]) r_req[i] = 1'b0;
        if (!r_req[i]) begin
          if (i == 0 && plan0.size() > 0) load(0, plan0.pop_front());
          else if (i == 1 && plan1.size() > 0) load(1, plan1.pop_front());
          else if (cont || (rnd && $urandom_range(1, 0) == 1)) load(i, rnd_txn());
        end
      end
    end
  end

  // monitor + reference model: predict grants, RAM drive and responses from the arbitration rules
  always @(negedge clk) begin
    bit eg, w;
    resp_t r;
    g_seen[0] = m0_gnt;
    g_seen[1] = m1_gnt;
    if (checking) begin
      eg = !busy && !rst && (r_req[0] || r_req[1]);
      w = (r_req[0] && r_req[1]) ? prio : r_req[1];
      chk("gnt", {62'h0, m1_gnt, m0_gnt}, eg ? (w ? 64'd2 : 64'd1) : 64'd0);
      chk("ram_we", ram_we, busy && pend.we && !rst);
      chk("ram_sel", ram_sel, busy ? pend.sel : 4'h0);
      chk("ram_addr", ram_addr, busy ? pend.addr : 32'h0);
      chk("ram_wdata", ram_wdata, busy ? pend.wdata : 32'h0);
      if (m0_ack || m1_ack) begin
        chk("single_ack", {m1_ack, m0_ack} == 2'b11, 0);
        if (sb.size() == 0) chk("unexpected_ack", {m1_ack, m0_ack}, 0);
        else begin
          r = sb.pop_front();
          chk("ack_id", m1_ack, r.id);
          chk("ack_cycle", cyc, r.cyc);
          chk("rdata", r.id ? m1_rdata : m0_rdata, r.data);
          chk("other_rdata", r.id ? m0_rdata : m1_rdata, 0);
        end
      end
      if (alt_chk && eg) begin
        chk("alternate", w, alt_exp);
        if (last_gcyc >= 0) chk("gnt_spacing", cyc - last_gcyc, 2);
        alt_exp = !alt_exp;
        last_gcyc = cyc;
      end
      if (rst) begin
        busy = 0; prio = 0;
      end else if (busy) begin
        r.id = pid;
        r.cyc = pcyc + 2;
        r.data = pend.we ? 32'h0 : ref_mem[pend.addr[7:2]];
        if (pend.we)
          for (int b = 0; b < 4; b++)
            if (pend.sel[b]) ref_mem[pend.addr[7:2]][8*b +: 8] = pend.wdata[8*b +: 8];
        sb.push_back(r);
        busy = 0;
      end else if (eg) begin
        busy = 1; pid = w; pcyc = cyc; prio = !w;
        pend = mk(r_we[w], r_sel[w], r_addr[w], r_wdata[w]);
      end
    end
  end

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk);
      done = plan0.size() == 0 && plan1.size() == 0 && !r_req[0] && !r_req[1] && !busy && sb.size() == 0;
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 checking = 1;
    plan0.push_back(mk(1, 4'hF, 32'h10, 32'hDEADBEEF));
    plan0.push_back(mk(0, 4'h0, 32'h10, 32'h0));
    @(negedge clk);
    chk("rst_ack", {m1_ack, m0_ack}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
    @(posedge clk);
    #1 rst = 0;
    drain();
    plan1.push_back(mk(1, 4'b0100, 32'h10, 32'h00AA0000));
    drain();
    plan0.push_back(mk(0, 4'h0, 32'h10, 32'h0));
    plan0.push_back(mk(1, 4'h0, 32'h10, 32'hFFFFFFFF));
    plan0.push_back(mk(0, 4'h0, 32'h10, 32'h0));
    plan0.push_back(mk(1, 4'hF, 32'h20, 32'h12345678));
    drain();
    plan0.push_back(mk(1, 4'hF, 32'h20, 32'hCAFEF00D));
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = m0_gnt;
      end
      chk("abort_gnt_seen", seen, 1);
    end
    @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    plan0.push_back(mk(0, 4'h0, 32'h20, 32'h0));
    drain();
    rst = 1; cont = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0; alt_chk = 1; alt_exp = 0; last_gcyc = -1;
    repeat (24) @(posedge clk);
    #1 cont = 0; alt_chk = 0;
    drain();
    rnd = 1;
    repeat (600) @(posedge clk);
    #1 rnd = 0;
    drain();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
